// File: rtl/pcie_sched_pkg.sv
// Shared definitions for the weighted round-robin class scheduler:
// FSM state encoding, class count, weight width and the class-index type.
package pcie_sched_pkg;

   localparam int NUM_CLASS = 4;
   localparam int WEIGHT_W  = 4;

   typedef logic [1:0] class_idx_t;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_INIT   = 2'd1,
      ST_ACTIVE = 2'd2,
      ST_STALL  = 2'd3
   } state_t;

endpackage

// File: rtl/next_class_finder.sv
// Rotate-priority search for the next eligible class after the current one
// (non-empty and non-zero weight), looking at cur+1, cur+2, cur+3 in that order.
module next_class_finder
   import pcie_sched_pkg::*;
(
   input  logic [NUM_CLASS-1:0] empty,
   input  logic [NUM_CLASS-1:0] nonzero,
   input  class_idx_t           cur,
   output logic                 found,
   output class_idx_t           idx
);

   class_idx_t cand;

   always_comb begin
      found = 1'b0;
      idx   = cur;
      cand  = cur;
      for (int unsigned k = 1; k < NUM_CLASS; k++) begin
         cand = cur + class_idx_t'(k);
         if (!found && !empty[cand] && nonzero[cand]) begin
            found = 1'b1;
            idx   = cand;
         end
      end
   end

endmodule

// File: rtl/wrr_scheduler.sv
// Weighted round-robin scheduler popping class FIFOs 0-3 into destination
// FIFOs, with per-class credit, back-pressure stall and runtime reconfiguration.
module wrr_scheduler #(
   parameter int NUM_CLASS = pcie_sched_pkg::NUM_CLASS,
   parameter int WEIGHT_W  = pcie_sched_pkg::WEIGHT_W
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          init,
   input  logic [NUM_CLASS*WEIGHT_W-1:0] weight_in,
   input  logic [NUM_CLASS-1:0]          empty,
   input  logic [NUM_CLASS-1:0]          dest_almost_full,
   output logic [NUM_CLASS-1:0]          pop,
   output logic [1:0]                    grant_id,
   output logic [WEIGHT_W-1:0]           credit,
   output logic [1:0]                    state
);

   import pcie_sched_pkg::*;

   state_t              cur_state, nxt_state;
   logic [WEIGHT_W-1:0] wt     [NUM_CLASS];
   logic [WEIGHT_W-1:0] nxt_wt [NUM_CLASS];
   class_idx_t          grant, nxt_grant;
   logic [WEIGHT_W-1:0] cred, nxt_cred;
   logic [NUM_CLASS-1:0] nonzero;
   logic                found;
   class_idx_t          found_idx;
   logic                go;

   always_comb begin
      nonzero = '0;
      for (int unsigned i = 0; i < NUM_CLASS; i++) nonzero[i] = (wt[i] != '0);
   end

   next_class_finder u_finder (
      .empty   (empty),
      .nonzero (nonzero),
      .cur     (grant),
      .found   (found),
      .idx     (found_idx)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cur_state <= ST_IDLE;
         grant     <= '0;
         cred      <= '0;
         for (int unsigned i = 0; i < NUM_CLASS; i++) wt[i] <= WEIGHT_W'(1);
      end else begin
         cur_state <= nxt_state;
         grant     <= nxt_grant;
         cred      <= nxt_cred;
         wt        <= nxt_wt;
      end
   end

   always_comb begin
      nxt_state = cur_state;
      nxt_grant = grant;
      nxt_cred  = cred;
      nxt_wt    = wt;
      pop       = '0;
      go        = (cur_state == ST_ACTIVE) && !(|dest_almost_full);

      if (go && !empty[grant] && cred != '0) pop[grant] = 1'b1;

      case (cur_state)
         ST_IDLE:   ;
         ST_INIT:   if (!init) nxt_state = ST_ACTIVE;
         ST_ACTIVE: if (|dest_almost_full) nxt_state = ST_STALL;
         ST_STALL:  if (!(|dest_almost_full)) nxt_state = ST_ACTIVE;
         default:   nxt_state = ST_IDLE;
      endcase

      // Last pop of a grant and a bubble cycle share one path: hand over, or reload in place.
      if (go) begin
         if (|pop && cred != WEIGHT_W'(1)) begin
            nxt_cred = cred - WEIGHT_W'(1);
         end else if (found) begin
            nxt_grant = found_idx;
            nxt_cred  = wt[found_idx];
         end else begin
            nxt_cred  = wt[grant];
         end
      end

      if (init) begin
         nxt_state = ST_INIT;
         for (int unsigned i = 0; i < NUM_CLASS; i++)
            nxt_wt[i] = weight_in[i*WEIGHT_W +: WEIGHT_W];
         nxt_grant = '0;
         nxt_cred  = weight_in[WEIGHT_W-1:0];
      end
   end

   assign grant_id = grant;
   assign credit   = cred;
   assign state    = cur_state;

endmodule

// File: tb/tb_wrr_scheduler.sv
// Bench for wrr_scheduler: directed scenarios plus randomized traffic, all
// compared cycle by cycle against a behavioural scheduler model.
module tb_wrr_scheduler;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        init = 1'b0;
   logic [15:0] weight_in = '0;
   logic [3:0]  empty = '0;
   logic [3:0]  dest_almost_full = '0;
   logic [3:0]  pop;
   logic [1:0]  grant_id;
   logic [3:0]  credit;
   logic [1:0]  state;

   int checks = 0;
   int errors = 0;

   int m_wt[4];
   int m_grant, m_credit, m_state;

   logic [3:0] s_pop, s_credit;
   logic [1:0] s_grant, s_state;

   always #5 clk = ~clk;

   wrr_scheduler #(.NUM_CLASS(4), .WEIGHT_W(4)) dut (
      .clk              (clk),
      .reset            (reset),
      .init             (init),
      .weight_in        (weight_in),
      .empty            (empty),
      .dest_almost_full (dest_almost_full),
      .pop              (pop),
      .grant_id         (grant_id),
      .credit           (credit),
      .state            (state)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [3:0] model_pop();
      if (m_state == 2 && dest_almost_full == 4'd0 && !empty[m_grant] && m_credit != 0)
         return 4'd1 << m_grant;
      return 4'd0;
   endfunction

   task automatic model_reset();
      m_state = 0; m_grant = 0; m_credit = 0;
      for (int i = 0; i < 4; i++) m_wt[i] = 1;
   endtask

   // Scheduler rules applied to the inputs present at the rising edge.
   task automatic model_step();
      int  ns = m_state;
      bit  go = (m_state == 2 && dest_almost_full == 4'd0);
      bit  p  = (model_pop() != 4'd0);
      int  nxt = -1;
      case (m_state)
         1: if (!init) ns = 2;
         2: if (dest_almost_full != 4'd0) ns = 3;
         3: if (dest_almost_full == 4'd0) ns = 2;
         default: ;
      endcase
      if (init) begin
         ns = 1;
         for (int i = 0; i < 4; i++) m_wt[i] = int'(weight_in[4*i +: 4]);
         m_grant = 0;
         m_credit = m_wt[0];
      end else if (go) begin
         if (p && m_credit > 1) m_credit = m_credit - 1;
         else begin
            for (int j = 1; j < 4; j++) begin
               int c = (m_grant + j) % 4;
               if (nxt < 0 && !empty[c] && m_wt[c] != 0) nxt = c;
            end
            if (nxt >= 0) m_grant = nxt;
            m_credit = m_wt[m_grant];
         end
      end
      m_state = ns;
   endtask

   task automatic step(input logic i_init, input logic [15:0] w, input logic [3:0] e,
                       input logic [3:0] d, input string tag);
      @(negedge clk);
      init = i_init; weight_in = w; empty = e; dest_almost_full = d;
      #1;
      s_pop = pop; s_grant = grant_id; s_credit = credit; s_state = state;
      check({tag, ".pop"},    32'(pop),      32'(model_pop()));
      check({tag, ".grant"},  32'(grant_id), 32'(m_grant));
      check({tag, ".credit"}, 32'(credit),   32'(m_credit));
      check({tag, ".state"},  32'(state),    32'(m_state));
      @(posedge clk);
      model_step();
   endtask

   task automatic do_reset(input int dly, input string tag);
      @(negedge clk);
      #(dly);
      reset = 1'b1;
      init = 1'b0;
      #1;
      check({tag, ".rst_pop"},    32'(pop),      32'd0);
      check({tag, ".rst_state"},  32'(state),    32'd0);
      check({tag, ".rst_grant"},  32'(grant_id), 32'd0);
      check({tag, ".rst_credit"}, 32'(credit),   32'd0);
      model_reset();
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic configure(input logic [15:0] w, input logic [3:0] e, input string tag);
      step(1'b1, w, e, 4'd0, tag);
      step(1'b1, w, e, 4'd0, tag);
      step(1'b0, w, e, 4'd0, tag);
   endtask

   initial begin
      int seq30[6] = '{0, 0, 0, 1, 2, 2};
      model_reset();
      do_reset(2, "por");

      // Equal weights: strict rotation, one pop per cycle.
      configure(16'h1111, 4'b0000, "w1111_cfg");
      for (int k = 0; k < 8; k++) begin
         step(1'b0, 16'h1111, 4'b0000, 4'd0, "w1111");
         check("w1111_seq", 32'(s_pop), 32'd1 << (k % 4));
      end

      // Weights {3,1,2,0}: class 3 is never served.
      configure(16'h0213, 4'b0000, "w3120_cfg");
      for (int k = 0; k < 12; k++) begin
         step(1'b0, 16'h0213, 4'b0000, 4'd0, "w3120");
         check("w3120_seq", 32'(s_pop), 32'd1 << seq30[k % 6]);
      end

      // Class 1 empties while holding credit 2.
      configure(16'h1231, 4'b0000, "empty_cfg");
      step(1'b0, 16'h1231, 4'b0000, 4'd0, "empty_a");
      step(1'b0, 16'h1231, 4'b0000, 4'd0, "empty_b");
      check("empty_b_credit", 32'(s_credit), 32'd3);
      step(1'b0, 16'h1231, 4'b0010, 4'd0, "empty_bubble");
      check("bubble_pop", 32'(s_pop), 32'd0);
      check("bubble_credit", 32'(s_credit), 32'd2);
      step(1'b0, 16'h1231, 4'b0010, 4'd0, "empty_move");
      check("move_grant", 32'(s_grant), 32'd2);
      check("move_credit", 32'(s_credit), 32'd2);
      check("move_pop", 32'(s_pop), 32'b0100);

      // Back-pressure for 5 cycles with grant=2, credit=1.
      for (int k = 0; k < 5; k++) begin
         step(1'b0, 16'h1231, 4'b0000, 4'b0100, "stall");
         check("stall_pop", 32'(s_pop), 32'd0);
         check("stall_grant", 32'(s_grant), 32'd2);
         check("stall_credit", 32'(s_credit), 32'd1);
         if (k > 0) check("stall_state", 32'(s_state), 32'd3);
      end
      step(1'b0, 16'h1231, 4'b0000, 4'd0, "release");
      check("release_pop", 32'(s_pop), 32'd0);
      step(1'b0, 16'h1231, 4'b0000, 4'd0, "resume");
      check("resume_pop", 32'(s_pop), 32'b0100);

      // Only class 2 has data: continuous pops, credit 2,1,2,1...
      configure(16'h1231, 4'b1011, "solo_cfg");
      step(1'b0, 16'h1231, 4'b1011, 4'd0, "solo_bubble");
      for (int k = 0; k < 8; k++) begin
         step(1'b0, 16'h1231, 4'b1011, 4'd0, "solo");
         check("solo_pop", 32'(s_pop), 32'b0100);
         check("solo_credit", 32'(s_credit), (k % 2 == 0) ? 32'd2 : 32'd1);
      end

      // All weights zero: nothing is ever popped.
      configure(16'h0000, 4'b0000, "zero_cfg");
      for (int k = 0; k < 6; k++) begin
         step(1'b0, 16'h0000, 4'b0000, 4'd0, "zero");
         check("zero_pop", 32'(s_pop), 32'd0);
      end

      // Asynchronous reset in the middle of a burst.
      configure(16'h2222, 4'b0000, "burst_cfg");
      for (int k = 0; k < 3; k++) step(1'b0, 16'h2222, 4'b0000, 4'd0, "burst");
      do_reset(3, "midburst");
      for (int k = 0; k < 5; k++) begin
         step(1'b0, 16'h2222, 4'($urandom), 4'd0, "post_rst");
         check("post_rst_pop", 32'(s_pop), 32'd0);
      end

      // Randomized traffic, reconfiguration and resets.
      for (int k = 0; k < 600; k++) begin
         int r = $urandom_range(0, 99);
         logic [15:0] w;
         logic [3:0]  e, d;
         for (int i = 0; i < 4; i++) w[4*i +: 4] = ($urandom_range(0, 9) == 0) ? 4'hF : 4'($urandom_range(0, 4));
         e = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'($urandom) & 4'($urandom);
         d = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'd0;
         if (r < 2) do_reset(int'($urandom_range(1, 4)), "rnd_rst");
         else step(r < 8, w, e, d, "rnd");
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout got=running exp=finished");
      $fatal(1, "bench timeout");
   end

endmodule
